// File: rtl/wb_queue.sv
// Write-back queue: merges load and ALU results into an in-order FIFO that
// retires one register-file write per cycle and exports a pending-write mask.
module wb_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [5:0]               ld_addr,
    input  logic [2:0]               ld_ppp,
    input  logic [63:0]              ld_data,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [5:0]               alu_addr,
    input  logic [2:0]               alu_ppp,
    input  logic [63:0]              alu_data,
    input  logic                     wb_hold,
    output logic                     wb_wr_en,
    output logic [2:0]               wb_ppp,
    output logic [5:0]               wb_addr,
    output logic [63:0]              wb_data,
    output logic [31:0]              pend_mask,
    output logic [$clog2(DEPTH):0]   count,
    output logic [7:0]               drop_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, alu_ptr;
    logic [CW-1:0]    count_q, count_d;
    logic [7:0]       drop_q, drop_d;
    logic [8:0]       drop_sum;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [4:0]       addr_q [DEPTH];
    logic [2:0]       ppp_q  [DEPTH];
    logic [63:0]      data_q [DEPTH];

    logic ld_fire, alu_fire, ld_store, alu_store, ld_drop, alu_drop, pop;

    // Register 0, out-of-range registers and reserved lanes are swallowed.
    function automatic logic legal(input logic [5:0] a, input logic [2:0] p);
        return (a != 6'd0) && !a[5] && (p <= 3'd4);
    endfunction

    always_comb begin
        ld_ready  = count_q <= CW'(DEPTH - 1);
        alu_ready = (ld_valid && ld_ready) ? (count_q <= CW'(DEPTH - 2))
                                           : (count_q <= CW'(DEPTH - 1));
        ld_fire   = ld_valid && ld_ready;
        alu_fire  = alu_valid && alu_ready;
        ld_store  = ld_fire && legal(ld_addr, ld_ppp);
        alu_store = alu_fire && legal(alu_addr, alu_ppp);
        ld_drop   = ld_fire && !ld_store;
        alu_drop  = alu_fire && !alu_store;
        pop       = (count_q != '0) && !wb_hold;
        alu_ptr   = wr_ptr_q + AW'(ld_store);

        wr_ptr_d  = wr_ptr_q + AW'(ld_store) + AW'(alu_store);
        rd_ptr_d  = rd_ptr_q + AW'(pop);
        count_d   = count_q + CW'(ld_store) + CW'(alu_store) - CW'(pop);

        drop_sum  = {1'b0, drop_q} + 9'(ld_drop) + 9'(alu_drop);
        drop_d    = drop_sum[8] ? 8'hff : drop_sum[7:0];

        valid_d = valid_q;
        if (pop)       valid_d[rd_ptr_q] = 1'b0;
        if (ld_store)  valid_d[wr_ptr_q] = 1'b1;
        if (alu_store) valid_d[alu_ptr]  = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
            valid_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
            valid_q  <= valid_d;
        end
    end

    // Payload needs no reset; valid bits and count guard every read.
    always_ff @(posedge clk) begin
        if (ld_store) begin
            addr_q[wr_ptr_q] <= ld_addr[4:0];
            ppp_q[wr_ptr_q]  <= ld_ppp;
            data_q[wr_ptr_q] <= ld_data;
        end
        if (alu_store) begin
            addr_q[alu_ptr] <= alu_addr[4:0];
            ppp_q[alu_ptr]  <= alu_ppp;
            data_q[alu_ptr] <= alu_data;
        end
    end

    always_comb begin
        wb_wr_en = pop;
        wb_addr  = pop ? {1'b0, addr_q[rd_ptr_q]} : 6'd0;
        wb_ppp   = pop ? ppp_q[rd_ptr_q] : 3'd0;
        wb_data  = pop ? data_q[rd_ptr_q] : 64'd0;
        count    = count_q;
        drop_cnt = drop_q;
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i]) pend_mask[addr_q[i]] = 1'b1;
        end
    end

endmodule
